// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline register with a 2-entry skid buffer, registered in_ready,
// synchronous bubble-injecting flush and a saturating bubble counter.
module pipe_stage_skid #(
    parameter int unsigned            DATA_W      = 64,
    parameter int unsigned            CTRL_W      = 24,
    parameter logic [CTRL_W-1:0]      CTRL_BUBBLE = '0,
    parameter int unsigned            CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic              accept;
    logic              drain;

    assign in_ready  = !s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_valid ? m_ctrl : CTRL_BUBBLE;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    assign accept = in_valid && in_ready;
    assign drain  = m_valid && out_ready;

    // S is only ever occupied while M is, so three cases cover every state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= CTRL_BUBBLE;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= CTRL_BUBBLE;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= CTRL_BUBBLE;
            s_valid <= 1'b0;
            s_ctrl  <= CTRL_BUBBLE;
        end else if (!m_valid) begin
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= in_data;
                m_ctrl  <= in_ctrl;
            end
        end else if (!s_valid) begin
            if (drain && accept) begin
                m_data <= in_data;
                m_ctrl <= in_ctrl;
            end else if (drain) begin
                m_valid <= 1'b0;
            end else if (accept) begin
                s_valid <= 1'b1;
                s_data  <= in_data;
                s_ctrl  <= in_ctrl;
            end
        end else if (drain) begin
            m_data  <= s_data;
            m_ctrl  <= s_ctrl;
            s_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bubble_cnt <= '0;
        end else if (out_ready && !m_valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_pipe_stage_skid;

    localparam logic [23:0] BUB_A = 24'h00ABCD;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic [23:0] in_ctrl = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a;
    logic [63:0] out_data_a;
    logic [23:0] out_ctrl_a;
    logic [1:0]  occ_a;
    logic [15:0] cnt_a;

    logic        in_ready_b, out_valid_b;
    logic [63:0] out_data_b;
    logic [23:0] out_ctrl_b;
    logic [1:0]  occ_b;
    logic [2:0]  cnt_b;

    pipe_stage_skid #(.DATA_W(64), .CTRL_W(24), .CTRL_BUBBLE(BUB_A), .CNT_W(16)) dut_a (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_ctrl(out_ctrl_a), .occupancy(occ_a), .bubble_cnt(cnt_a)
    );

    pipe_stage_skid #(.DATA_W(64), .CTRL_W(24), .CTRL_BUBBLE(24'h0), .CNT_W(3)) dut_b (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_ctrl(out_ctrl_b), .occupancy(occ_b), .bubble_cnt(cnt_b)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mq_data[$];
    logic [23:0] mq_ctrl[$];
    int unsigned mcnt_a = 0;
    int unsigned mcnt_b = 0;
    logic [63:0] seen[$];
    logic        pre_valid;
    logic [63:0] pre_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq_data.delete();
        mq_ctrl.delete();
        mcnt_a = 0;
        mcnt_b = 0;
    endtask

    // Abstract behaviour: a FIFO of at most two beats, head visible downstream.
    task automatic model_update();
        bit acc, drn;
        acc = in_valid && (mq_data.size() < 2);
        drn = (mq_data.size() > 0) && out_ready;
        if (out_ready && mq_data.size() == 0) begin
            if (mcnt_a < 65535) mcnt_a++;
            if (mcnt_b < 7) mcnt_b++;
        end
        if (pre_valid && out_ready) seen.push_back(pre_data);
        if (flush) begin
            mq_data.delete();
            mq_ctrl.delete();
        end else begin
            if (drn) begin
                void'(mq_data.pop_front());
                void'(mq_ctrl.pop_front());
            end
            if (acc) begin
                mq_data.push_back(in_data);
                mq_ctrl.push_back(in_ctrl);
            end
        end
    endtask

    task automatic compare_all();
        int n;
        n = mq_data.size();
        chk("a.in_ready", in_ready_a, n < 2);
        chk("a.out_valid", out_valid_a, n > 0);
        chk("a.occupancy", occ_a, n);
        chk("a.out_ctrl", out_ctrl_a, (n > 0) ? mq_ctrl[0] : BUB_A);
        if (n > 0) chk("a.out_data", out_data_a, mq_data[0]);
        chk("a.bubble_cnt", cnt_a, mcnt_a);
        chk("b.out_valid", out_valid_b, n > 0);
        chk("b.occupancy", occ_b, n);
        chk("b.out_ctrl", out_ctrl_b, (n > 0) ? mq_ctrl[0] : 24'h0);
        if (n > 0) chk("b.out_data", out_data_b, mq_data[0]);
        chk("b.bubble_cnt", cnt_b, mcnt_b);
    endtask

    task automatic step();
        pre_valid = out_valid_a;
        pre_data  = out_data_a;
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic send(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = d[23:0] ^ 24'h5A0000;
        step();
    endtask

    task automatic async_reset();
        #1 RST = 1'b0;
        #1 model_clear();
        chk("rst.out_valid", out_valid_a, 0);
        chk("rst.in_ready", in_ready_a, 1);
        chk("rst.occupancy", occ_a, 0);
        chk("rst.out_data", out_data_a, 0);
        chk("rst.out_ctrl", out_ctrl_a, BUB_A);
        chk("rst.bubble_cnt", cnt_a, 0);
        #1 RST = 1'b1;
    endtask

    initial begin
        int ca;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        model_clear();
        compare_all();
        chk("init.out_data", out_data_a, 0);

        // streaming at one beat per cycle
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(64'(i));
            chk("stream.out_data", out_data_a, 64'(i));
            chk("stream.occupancy", occ_a, 1);
        end
        chk("stream.bubble_cnt", cnt_a, 1);
        in_valid = 1'b0;
        step();

        // skid fill and in-order drain
        seen.delete();
        out_ready = 1'b0;
        send(64'hA);
        send(64'hB);
        chk("skid.occupancy", occ_a, 2);
        chk("skid.in_ready", in_ready_a, 0);
        send(64'hC);
        chk("skid.hold_occ", occ_a, 2);
        out_ready = 1'b1;
        send(64'hC);
        chk("skid.ready_back", in_ready_a, 1);
        chk("skid.head_B", out_data_a, 64'hB);
        send(64'hC);
        in_valid = 1'b0;
        step();
        step();
        chk("skid.seen_n", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("skid.seen0", seen[0], 64'hA);
            chk("skid.seen1", seen[1], 64'hB);
            chk("skid.seen2", seen[2], 64'hC);
        end

        // flush while full, with a simultaneous beat that must vanish
        out_ready = 1'b0;
        send(64'hA1);
        send(64'hB1);
        seen.delete();
        flush = 1'b1;
        send(64'hD1);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush.out_valid", out_valid_a, 0);
        chk("flush.out_ctrl", out_ctrl_a, BUB_A);
        chk("flush.occupancy", occ_a, 0);
        chk("flush.in_ready", in_ready_a, 1);
        out_ready = 1'b1;
        step();
        step();
        chk("flush.seen_n", seen.size(), 0);

        // flush coinciding with a drain
        out_ready = 1'b0;
        send(64'hA2);
        in_valid = 1'b0;
        seen.delete();
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        chk("fdrain.seen_n", seen.size(), 1);
        if (seen.size() == 1) chk("fdrain.seen0", seen[0], 64'hA2);
        chk("fdrain.occupancy", occ_a, 0);

        // bubble counter saturation on the 3-bit instance
        async_reset();
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            ca = (i < 7) ? i : 7;
            chk("sat.cnt_b", cnt_b, ca);
            chk("sat.cnt_a", cnt_a, i);
        end

        // asynchronous reset while full, then first beat after release
        out_ready = 1'b0;
        send(64'h11);
        send(64'h22);
        chk("arst.occ_before", occ_a, 2);
        async_reset();
        send(64'h55);
        in_valid = 1'b0;
        chk("arst.out_data", out_data_a, 64'h55);
        chk("arst.out_valid", out_valid_a, 1);
        chk("arst.occupancy", occ_a, 1);
        out_ready = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked successor to the fixed-field ID/EX freeze register.
- Carries one payload bus and one control bus between pipeline stages using a valid/ready handshake and a 2-entry skid buffer, so that `in_ready` is a registered signal.
- Provides a synchronous flush that injects a bubble, forcing control to a safe NOP encoding, plus a saturating bubble counter for performance debug.
- Instantiated between any two stages: IF/ID, ID/EX, EX/MEM, MEM/WB.

Parameters:
- DATA_W, 64, payload width (PC, operands, immediate, register indices packed by the instantiating stage).
- CTRL_W, 24, control-field width (regWrite, memRead/memWrite, ALUOp, etc.).
- CTRL_BUBBLE, 0, control value presented on `out_ctrl` whenever `out_valid`=0, and the reset/flush value.
- CNT_W, 16, width of the bubble counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  stage can accept a beat (registered).
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- flush  in  1  synchronous kill of all held beats (branch/jump mispredict).
- out_valid  out  1  stage holds a beat for downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control, or CTRL_BUBBLE when empty.
- occupancy  out  2  beats held: 0, 1 or 2.
- bubble_cnt  out  CNT_W  saturating count of bubble cycles.

Behaviour:
- Storage:
  - Main register M (`m_valid`, `m_data`, `m_ctrl`) drives the outputs.
  - Skid register S (`s_valid`, `s_data`, `s_ctrl`) holds the overflow beat.
- Handshakes:
  - Accept = `in_valid` & `in_ready`.
  - Drain = `out_valid` & `out_ready`.
- Outputs:
  - `in_ready` = !`s_valid` (register output, no combinational path from `out_ready`).
  - `out_valid` = `m_valid`.
  - `out_data` = `m_data`.
  - `out_ctrl` = `m_valid` ? `m_ctrl` : CTRL_BUBBLE.
  - `occupancy` = `m_valid` + `s_valid`.
- Next-state, evaluated at each posedge when `flush`=0:
  - Empty, accept: load M; occupancy 1.
  - M only, drain & accept: M <= input.
  - M only, drain, no accept: M cleared; occupancy 0.
  - M only, accept, no drain: S <= input; occupancy 2; `in_ready` falls next cycle.
  - M only, neither: hold.
  - Full (M+S), drain: M <= S, S cleared. No accept is possible because `in_ready`=0.
  - Full, no drain: hold all.
- Ordering: beats leave in arrival order. No beat is ever dropped or duplicated except by flush.
- Flush (`flush`=1 at posedge):
  - `m_valid` and `s_valid` <= 0.
  - `m_ctrl` and `s_ctrl` <= CTRL_BUBBLE.
  - Data registers may retain stale values.
  - A simultaneous input beat is consumed (`in_ready` was 1) and discarded.
  - A simultaneous drain completes normally on the downstream side.
  - Flush takes priority over every other transition.
- Bubble counter:
  - Increments at a posedge when `out_ready`=1 and `out_valid`=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Latency and throughput:
  - Latency is 1 cycle from accept to `out_valid`.
  - Sustains 1 beat per cycle when `out_ready` is held high.
- Reset (RST=0, asynchronous, mid-operation allowed):
  - `m_valid` = `s_valid` = 0.
  - All data registers 0; `m_ctrl` = `s_ctrl` = CTRL_BUBBLE.
  - `bubble_cnt` = 0.
  - Resulting outputs: `in_ready`=1, `out_valid`=0, `out_ctrl`=CTRL_BUBBLE, `out_data`=0, `occupancy`=0.
  - Held beats are lost.
  - `in_ready` is high after release, so the first posedge after release may accept.

Test Plan:
1. Streaming: reset, then `out_ready`=1 and `in_valid`=1 with `in_data`=1,2,3… for 10 cycles -> `out_data` = 1,2,3… each one cycle later; `occupancy` stays 1; `bubble_cnt`=1 (first cycle only).
2. Skid fill: M holds A, `out_ready`=0, send B -> `occupancy`=2 and `in_ready`=0 next cycle; C is held off. Raise `out_ready` -> A then B then C drain in order, `in_ready` returns to 1 after A drains.
3. Flush while full: A in M, B in S, `flush`=1 with `in_valid`=1 (D) -> next cycle `out_valid`=0, `out_ctrl`=CTRL_BUBBLE, `occupancy`=0, `in_ready`=1; D never appears.
4. Flush plus drain: A in M, `out_ready`=1, `flush`=1 at the same edge -> A is seen downstream exactly once; the stage is empty afterwards.
5. Bubble saturation with CNT_W=3: `out_ready`=1 and no input for 12 cycles -> `bubble_cnt` goes 1…7 and holds at 7.
6. Async reset mid-operation: `occupancy`=2, assert RST low between clock edges -> outputs take reset values immediately, without a clock. After release, send beat 0x55 -> `out_data`=0x55 one cycle later.
